pattern_detector: RTL and testbench



---
 rtl/pattern_pkg.sv | 13 +
 rtl/sat_counter.sv | 22 ++
 rtl/pattern_detector.sv | 91 +++++++++
 tb/tb_pattern_detector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and parameter limits for the serial pattern detector.
package pattern_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial N-bit pattern detector with run-time loadable pattern and overlap control.
// Define MATCH_COUNT_EN to add the saturating match_count output.
module pattern_detector
  import pattern_pkg::*;
#(
  parameter int unsigned   N       = 3,
  parameter logic [N-1:0]  PATTERN = N'(3'b011),
  parameter int unsigned   COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               In,
  input  logic               valid_in,
  input  logic               overlap,
  input  logic               pattern_ld,
  input  logic [N-1:0]       pattern_in,
  output logic               Out
`ifdef MATCH_COUNT_EN
  ,
  output logic [COUNT_W-1:0] match_count
`endif
);

  localparam int unsigned FILL_W = $clog2(N + 1);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
    $error("pattern_detector: N out of range");
  end
  if (COUNT_W == 0) begin : g_bad_count_w
    $error("pattern_detector: COUNT_W must be nonzero");
  end

  logic [N-1:0]      hist;
  logic [N-1:0]      hist_nx;
  logic [N-1:0]      pat;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nx;
  logic              full_nx;
  logic              hit;
  state_t            state;

  // Window contents and match decision if the current bit is accepted.
  always_comb begin
    hist_nx = {hist[N-2:0], In};
    full_nx = (state == ARMED) || (fill == FILL_W'(N - 1));
    fill_nx = full_nx ? FILL_W'(N) : fill + FILL_W'(1);
    hit     = full_nx && (hist_nx == pat);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= PATTERN;
      state <= EMPTY;
      Out   <= 1'b0;
    end else if (pattern_ld) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= pattern_in;
      state <= EMPTY;
      Out   <= 1'b0;
    end else if (valid_in) begin
      hist <= hist_nx;
      Out  <= hit;
      // Non-overlapping mode restarts the window so the next match needs N fresh bits.
      if (hit && !overlap) begin
        fill  <= '0;
        state <= EMPTY;
      end else begin
        fill  <= fill_nx;
        state <= full_nx ? ARMED : FILLING;
      end
    end else begin
      Out <= 1'b0;
    end
  end

`ifdef MATCH_COUNT_EN
  sat_counter #(
    .W(COUNT_W)
  ) u_match_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (1'b0),
    .inc  (valid_in && !pattern_ld && hit),
    .count(match_count)
  );
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: reference model of the sliding-window rules plus literal traces.
module tb_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_a, v_a, ov_a, ld_a;
  logic [2:0] pin_a;
  logic       out_a;
  logic       in_b, v_b, ov_b, ld_b;
  logic [1:0] pin_b;
  logic       out_b;
`ifdef MATCH_COUNT_EN
  logic [7:0] mc_a;
  logic [1:0] mc_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  logic [31:0] trace_a, trace_b;

  pattern_detector #(.N(3), .PATTERN(3'b011), .COUNT_W(8)) dut_a (
    .clock(clk), .reset(rst), .In(in_a), .valid_in(v_a), .overlap(ov_a),
    .pattern_ld(ld_a), .pattern_in(pin_a), .Out(out_a)
`ifdef MATCH_COUNT_EN
    , .match_count(mc_a)
`endif
  );

  pattern_detector #(.N(2), .PATTERN(2'b11), .COUNT_W(2)) dut_b (
    .clock(clk), .reset(rst), .In(in_b), .valid_in(v_b), .overlap(ov_b),
    .pattern_ld(ld_b), .pattern_in(pin_b), .Out(out_b)
`ifdef MATCH_COUNT_EN
    , .match_count(mc_b)
`endif
  );

  // Reference: keep the accepted bits as a list; a match is "last n bits spell the pattern".
  function automatic logic window_hit(input bit q[$], input logic [15:0] p, input int n);
    logic [15:0] v;
    v = '0;
    if (q.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) v = {v[14:0], 1'(q[i])};
    return v == p;
  endfunction

  bit qa[$];
  bit qb[$];
  logic [2:0] pa;
  logic [1:0] pb;
  logic ea, eb;
  int unsigned ca, cb;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete(); pa = 3'b011; ea = 1'b0; ca = 0;
    end else if (ld_a) begin
      qa.delete(); pa = pin_a; ea = 1'b0;
    end else if (v_a) begin
      qa.push_back(in_a);
      if (qa.size() > 3) void'(qa.pop_front());
      ea = window_hit(qa, 16'(pa), 3);
      if (ea) begin
        if (ca < 255) ca++;
        if (!ov_a) qa.delete();
      end
    end else begin
      ea = 1'b0;
    end

    if (rst) begin
      qb.delete(); pb = 2'b11; eb = 1'b0; cb = 0;
    end else if (ld_b) begin
      qb.delete(); pb = pin_b; eb = 1'b0;
    end else if (v_b) begin
      qb.push_back(in_b);
      if (qb.size() > 2) void'(qb.pop_front());
      eb = window_hit(qb, 16'(pb), 2);
      if (eb) begin
        if (cb < 3) cb++;
        if (!ov_b) qb.delete();
      end
    end else begin
      eb = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (out_a !== ea) begin
        miscompares++;
        $display("FAIL model_out_a @%0t: got %b expected %b", $time, out_a, ea);
      end
      vectors++;
      if (out_b !== eb) begin
        miscompares++;
        $display("FAIL model_out_b @%0t: got %b expected %b", $time, out_b, eb);
      end
`ifdef MATCH_COUNT_EN
      vectors++;
      if (mc_a !== 8'(ca)) begin
        miscompares++;
        $display("FAIL model_count_a @%0t: got %0d expected %0d", $time, mc_a, ca);
      end
      vectors++;
      if (mc_b !== 2'(cb)) begin
        miscompares++;
        $display("FAIL model_count_b @%0t: got %0d expected %0d", $time, mc_b, cb);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt_a(input string name, input int exp);
`ifdef MATCH_COUNT_EN
    chk(name, 32'(mc_a), 32'(exp));
`endif
  endtask

  task automatic drive_a(input logic v, input logic b, input logic ld, input logic [2:0] p);
    v_a = v; in_a = b; ld_a = ld; pin_a = p;
    @(posedge clk); #1;
    trace_a = {trace_a[30:0], out_a};
    v_a = 1'b0; ld_a = 1'b0;
  endtask

  task automatic step_a(input logic v, input logic b);
    drive_a(v, b, 1'b0, 3'b000);
  endtask

  task automatic step_b(input logic v, input logic b);
    v_b = v; in_b = b;
    @(posedge clk); #1;
    trace_b = {trace_b[30:0], out_b};
    v_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_out_a", 32'(out_a), 32'd0);
    chk_cnt_a("reset_count_a", 0);
    trace_a = '0;
    trace_b = '0;
  endtask

  initial begin
    logic [9:0] legacy;
    logic [4:0] alt;
    rst = 1'b1;
    in_a = 1'b0; v_a = 1'b0; ov_a = 1'b0; ld_a = 1'b0; pin_a = '0;
    in_b = 1'b0; v_b = 1'b0; ov_b = 1'b0; ld_b = 1'b0; pin_b = 2'b11;
    trace_a = '0; trace_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();

    // Legacy "011" stream, non-overlapping
    ov_a = 1'b0;
    legacy = 10'b0100110111;
    for (int i = 9; i >= 0; i--) step_a(1'b1, legacy[i]);
    chk("legacy_trace", trace_a & 32'h3ff, 32'b0000010010);
    chk_cnt_a("legacy_count", 2);

    // Self-overlapping "101"
    alt = 5'b10101;
    do_reset();
    ov_a = 1'b1;
    drive_a(1'b0, 1'b0, 1'b1, 3'b101);
    trace_a = '0;
    for (int i = 4; i >= 0; i--) step_a(1'b1, alt[i]);
    chk("overlap_on_trace", trace_a & 32'h1f, 32'b00101);
    chk_cnt_a("overlap_on_count", 2);

    do_reset();
    ov_a = 1'b0;
    drive_a(1'b0, 1'b0, 1'b1, 3'b101);
    trace_a = '0;
    for (int i = 4; i >= 0; i--) step_a(1'b1, alt[i]);
    chk("overlap_off_trace", trace_a & 32'h1f, 32'b00100);
    chk_cnt_a("overlap_off_count", 1);

    // Bubbles between accepted bits
    do_reset();
    step_a(1'b1, 1'b0);
    step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b0, 1'b1);
    chk("gaps_trace", trace_a & 32'h3f, 32'b000010);
    chk_cnt_a("gaps_count", 1);

    // Load with a same-cycle valid bit that must be discarded
    do_reset();
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    drive_a(1'b1, 1'b1, 1'b1, 3'b110);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b0);
    chk("load_trace", trace_a & 32'h3f, 32'b000001);
    chk_cnt_a("load_count", 1);

    // Reset mid-stream; pattern back to 011
    do_reset();
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    do_reset();
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b1);
    chk("reset_mid_trace", trace_a & 32'hf, 32'b0001);
    chk_cnt_a("reset_mid_count", 1);

    // Saturation on the 2-bit instance: pattern 11, overlap, eight ones
    do_reset();
    ov_b = 1'b1;
    for (int i = 0; i < 8; i++) step_b(1'b1, 1'b1);
    chk("sat_trace", trace_b & 32'hff, 32'b01111111);
`ifdef MATCH_COUNT_EN
    chk("sat_count", 32'(mc_b), 32'd3);
`endif
    step_b(1'b0, 1'b1);
    chk("sat_idle_out", 32'(out_b), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
